uart_rx_param: RTL

Parametrised UART receiver for the serial front end: configurable data width, parity mode and stop-bit count, plus an oversampled bit clock with majority-vote sampling. It also detects framing errors, parity errors and line breaks. It sits between the pin-level `rx` line and byte consumers (FIFOs, protocol parsers). It replaces the fixed 8N1 receiver wherever non-8N1 framing or noise immunity is required.

---
 rtl/uart_rx_param.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver. Oversamples rx, decides each bit by a
//   2-of-3 majority around mid-bit, and reports clean frames, framing and
//   parity errors, and line breaks as one-cycle registered strobes.
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   rx          asynchronous serial line, idles high
//   data        last received word (updated at every frame end)
//   valid       strobe: clean frame
//   frame_err   strobe: a stop bit sampled low
//   parity_err  strobe: parity mismatch
//   break_det   strobe: all-zero frame including stop bits
//   busy        high from start-bit detection until back in idle
//
// state         | meaning
// ST_IDLE       | line idle, waiting for a falling edge on rx_s
// ST_START      | validating the start bit at mid-bit
// ST_DATA       | receiving data bits, LSB first
// ST_PARITY     | receiving and checking the parity bit
// ST_STOP       | receiving stop bits, frame ends at the last one
// ST_BREAK_WAIT | break reported, waiting for the line to go high
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 38_400,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TC_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SC_W     = $clog2(OVERSAMPLE);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [TC_W-1:0]  TC_RELOAD = TC_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0]  S_EARLY   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  S_MID     = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0]  S_LATE    = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0]  S_LAST    = SC_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  if (TICK_DIV < 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_rx_param: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK_WAIT
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [1:0]           fill;       // marks when rx_s reflects the real line after reset
  logic                 armed;      // rx_s has been seen high in idle since reset
  logic [TC_W-1:0]      tick_cnt;
  logic [SC_W-1:0]      sample_cnt;
  logic                 s_a, s_b;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_index;
  logic                 stop_cnt;
  logic                 par_err_l, stop_fault, all_zero;

  logic tick, start_det, decide, maj;

  assign tick      = (tick_cnt == '0);
  assign start_det = (state == ST_IDLE) && armed && !rx_s;
  assign decide    = tick && (sample_cnt == S_LATE);
  assign maj       = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);

  // Synchroniser, tick divider and sample capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      fill       <= 2'b00;
      tick_cnt   <= '0;
      sample_cnt <= '0;
      s_a        <= 1'b1;
      s_b        <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      fill <= {fill[0], 1'b1};
      if (start_det) begin
        tick_cnt   <= '0;
        sample_cnt <= '0;
      end else begin
        tick_cnt <= tick ? TC_RELOAD : tick_cnt - 1'b1;
        if (tick)
          sample_cnt <= (sample_cnt == S_LAST) ? '0 : sample_cnt + 1'b1;
      end
      if (tick && sample_cnt == S_EARLY) s_a <= rx_s;
      if (tick && sample_cnt == S_MID)   s_b <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      shift_reg  <= '0;
      bit_index  <= '0;
      stop_cnt   <= 1'b0;
      par_err_l  <= 1'b0;
      stop_fault <= 1'b0;
      all_zero   <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fill[1] && rx_s) armed <= 1'b1;
          if (start_det) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (decide) begin
            if (maj) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state      <= ST_DATA;
              bit_index  <= '0;
              stop_cnt   <= 1'b0;
              par_err_l  <= 1'b0;
              stop_fault <= 1'b0;
              all_zero   <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (decide) begin
            shift_reg[bit_index] <= maj;
            if (maj) all_zero <= 1'b0;
            if (bit_index == LAST_IDX)
              state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            else
              bit_index <= bit_index + 1'b1;
          end
        end
        ST_PARITY: begin
          if (decide) begin
            // XOR over data+parity must be 1 for odd, 0 for even.
            par_err_l <= (^shift_reg) ^ maj ^ (PARITY == 1);
            if (maj) all_zero <= 1'b0;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              data <= shift_reg;
              if (all_zero && !maj) begin
                break_det <= 1'b1;
                state     <= ST_BREAK_WAIT;
              end else begin
                frame_err  <= stop_fault | ~maj;
                parity_err <= par_err_l;
                valid      <= !(stop_fault | ~maj) && !par_err_l;
                state      <= ST_IDLE;
                busy       <= 1'b0;
              end
            end else begin
              stop_cnt   <= 1'b1;
              stop_fault <= stop_fault | ~maj;
              if (maj) all_zero <= 1'b0;
            end
          end
        end
        ST_BREAK_WAIT: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
